// File: rtl/psum_acc_wb_if.sv
// -----------------------------------------------------------------------------
// psum_acc_wb_if
// Bundles the partial-sum input handshake and the output feature-map SRAM port
// used by psum_acc_wb.
//   in_valid/in_ready  : one partial sum per handshake
//   in_addr/in_psum    : target pixel and signed partial sum
//   in_first/in_final  : first channel pass (overwrite) / last pass (ReLU+tag)
//   sram_we/addr/din   : SRAM write enable, shared read/write address, data
//   sram_dout          : SRAM read data, one cycle after the address
//   sram_final_flag    : tags a final-pass write
// Modports: master = upstream/SRAM side, slave = the accumulate stage.
// -----------------------------------------------------------------------------
interface psum_acc_wb_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 26
);
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_addr;
   logic [DATA_W-1:0] in_psum;
   logic              in_first;
   logic              in_final;
   logic              sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_din;
   logic [DATA_W-1:0] sram_dout;
   logic              sram_final_flag;

   modport master (
      output in_valid, in_addr, in_psum, in_first, in_final, sram_dout,
      input  in_ready, sram_we, sram_addr, sram_din, sram_final_flag
   );

   modport slave (
      input  in_valid, in_addr, in_psum, in_first, in_final, sram_dout,
      output in_ready, sram_we, sram_addr, sram_din, sram_final_flag
   );
endinterface

// File: rtl/psum_acc_wb.sv
// -----------------------------------------------------------------------------
// psum_acc_wb
// Partial-sum accumulate / write-back stage in front of the output feature-map
// SRAM. First pass overwrites a word; later passes read-modify-write with
// signed saturation; the final pass applies ReLU, tags the write, and a
// one-cycle done pulse fires once every word of the map has been finalised.
// Ports:
//   clk, rst  : single clock, synchronous active-high reset
//   bus       : psum_acc_wb_if.slave (input handshake + SRAM port)
//   done      : one-cycle pulse, all WORD_AMOUNT words finalised
//   sat_flag  : sticky, some accumulate saturated
//   addr_err  : sticky, some input address was >= WORD_AMOUNT
// -----------------------------------------------------------------------------
module psum_acc_wb #(
   parameter int WORD_AMOUNT = 3136,
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 26
) (
   input  logic                clk,
   input  logic                rst,
   psum_acc_wb_if.slave        bus,
   output logic                done,
   output logic                sat_flag,
   output logic                addr_err
);
   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   localparam logic [ADDR_W:0]   L_WORDS    = (ADDR_W+1)'(WORD_AMOUNT);
   localparam logic [ADDR_W:0]   L_LAST_CNT = (ADDR_W+1)'(WORD_AMOUNT - 1);
   localparam logic [DATA_W-1:0] L_MAX      = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] L_MIN      = {1'b1, {(DATA_W-1){1'b0}}};

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_psum;
   logic              r_first;
   logic              r_final;
   logic              r_oob;
   logic [ADDR_W:0]   r_cnt;
   logic              r_done;
   logic              r_sat;
   logic              r_err;

   logic              w_ready;
   logic              w_xfer;
   logic              w_wr;
   logic              w_commit;
   logic [DATA_W:0]   w_sum;
   logic              w_ovf;
   logic [DATA_W-1:0] w_acc;
   logic [DATA_W-1:0] w_pre;
   logic [DATA_W-1:0] w_res;
   logic              w_cnt_hit;

   assign w_ready = ((r_state == IDLE) || (r_state == WRITE)) && !rst;
   assign w_xfer  = bus.in_valid && w_ready;

   // Gating with rst drops the pending element's write when reset lands mid-flight.
   assign w_wr     = (r_state == WRITE) && !rst;
   assign w_commit = w_wr && !r_oob;

   // One extra bit holds the true sum; overflow shows as the top two bits differing.
   assign w_sum = {bus.sram_dout[DATA_W-1], bus.sram_dout} + {r_psum[DATA_W-1], r_psum};
   assign w_ovf = w_sum[DATA_W] != w_sum[DATA_W-1];
   assign w_acc = w_ovf ? (w_sum[DATA_W] ? L_MIN : L_MAX) : w_sum[DATA_W-1:0];

   // ReLU applies after the overwrite/saturate choice.
   assign w_pre = r_first ? r_psum : w_acc;
   assign w_res = (r_final && w_pre[DATA_W-1]) ? '0 : w_pre;

   assign w_cnt_hit = w_commit && r_final && (r_cnt == L_LAST_CNT);

   assign bus.in_ready        = w_ready;
   assign bus.sram_we         = w_commit;
   assign bus.sram_addr       = r_addr;      // holds the last address outside READ/WRITE
   assign bus.sram_din        = w_wr ? w_res : '0;
   assign bus.sram_final_flag = w_commit && r_final;

   assign done     = r_done;
   assign sat_flag = r_sat;
   assign addr_err = r_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_psum  <= '0;
         r_first <= 1'b0;
         r_final <= 1'b0;
         r_oob   <= 1'b0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_sat   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= w_cnt_hit;

         if (w_wr && !r_first && w_ovf) begin
            r_sat <= 1'b1;
         end

         if (w_commit && r_final) begin
            r_cnt <= w_cnt_hit ? '0 : r_cnt + 1'b1;
         end

         if (w_xfer) begin
            r_addr  <= bus.in_addr;
            r_psum  <= bus.in_psum;
            r_first <= bus.in_first;
            r_final <= bus.in_final;
            r_oob   <= {1'b0, bus.in_addr} >= L_WORDS;
            if ({1'b0, bus.in_addr} >= L_WORDS) begin
               r_err <= 1'b1;
            end
            r_state <= bus.in_first ? WRITE : READ;
         end else begin
            case (r_state)
               READ:    r_state <= WRITE;
               WRITE:   r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: doc/psum_acc_wb.md
# psum_acc_wb

Partial-sum accumulate/write-back stage directly upstream of the output feature-map SRAM (3136 x 26-bit, 56x56 map). Accepts one partial sum per handshake from the PE array and writes it to the SRAM. On the first input-channel pass it overwrites the word; on later passes it does a read-modify-write with signed saturation. On the final pass it applies ReLU, tags the write with `final_flag`, and pulses `done` once every word of the map has been finalised.

## Interface
- `WORD_AMOUNT`, 3136, words in the output SRAM / pixels per map
- `ADDR_W`, 12, address width, equal to $clog2(WORD_AMOUNT)
- `DATA_W`, 26, partial-sum and SRAM word width, two's complement
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  partial sum present
- `in_ready`  out  1  stage can accept this cycle
- `in_addr`  in  ADDR_W  target pixel address
- `in_psum`  in  DATA_W  signed partial sum
- `in_first`  in  1  first channel pass: overwrite, no read
- `in_final`  in  1  last channel pass: ReLU + final tag
- `sram_we`  out  1  SRAM write enable
- `sram_addr`  out  ADDR_W  SRAM address (read or write)
- `sram_din`  out  DATA_W  SRAM write data
- `sram_dout`  in  DATA_W  SRAM read data, valid the cycle after the read address is presented
- `sram_final_flag`  out  1  high with `sram_we` on a final-pass write
- `done`  out  1  one-cycle pulse: all WORD_AMOUNT words finalised
- `sat_flag`  out  1  sticky: any accumulate saturated
- `addr_err`  out  1  sticky: an input had `in_addr` >= WORD_AMOUNT

## Operation
- FSM states: IDLE, READ, WRITE. Reset enters IDLE.
- `in_ready` = (state==IDLE or state==WRITE) and not `rst`. A transfer occurs on `in_valid & in_ready`.
- On transfer, `addr`, `psum`, `first` and `final` are registered into a single pending slot.
  - Next state is WRITE if `first`, otherwise READ.
  - With no transfer: IDLE stays IDLE, and WRITE goes to IDLE.
- READ (one cycle): `sram_addr`=pending addr, `sram_we`=0; always goes to WRITE.
- WRITE: `sram_we`=1, `sram_addr`=pending addr, `sram_din`=result.
  - If `first`: result = psum.
  - Otherwise: sum = `sram_dout` + psum, computed at DATA_W+1 bits, then clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Any clamp sets `sat_flag`.
  - If `final`: result = 0 when negative (ReLU after saturation). `sram_final_flag`=1.
  - `first` and `final` may both be set (single-channel layer): overwrite, then ReLU.
- Out-of-range address: the element is still consumed and READ/WRITE still sequence, but `sram_we` is forced to 0, `addr_err` is set, and the element does not count toward `done`.
- Final counter (ADDR_W+1 bits) increments on each final-pass write.
  - On the write that brings it to WORD_AMOUNT, the counter clears to 0 and `done` pulses in the next cycle.
  - Duplicate final writes to the same address count; upstream guarantees uniqueness.
- Outside WRITE: `sram_we`=0, `sram_final_flag`=0, `sram_addr` holds its last value, `sram_din`=0.

## Timing
- Reset values: state IDLE, `in_ready`=0 while `rst` is high (1 in the first cycle after release), `sram_we`=0, `sram_addr`=0, `sram_din`=0, `sram_final_flag`=0, `done`=0, `sat_flag`=0, `addr_err`=0, final counter 0, pending slot cleared.
- First-pass latency: transfer at edge N, write driven during cycle N+1, committed at edge N+1. Back-to-back throughput is 1 element/cycle.
- Accumulate latency: transfer at edge N, READ during N+1, WRITE during N+2, committed at edge N+2. Throughput is 1 element per 2 cycles.
- A transfer during WRITE overlaps the current write; the new element's READ starts the following cycle. This gives no read/write address-port conflict and no hazard, even for the same address, because the write commits before the next read.
- `done` is registered and high for exactly 1 cycle.
- Reset mid-operation, including in READ/WRITE: the pending element is dropped with no write that cycle, counters and sticky flags are cleared, and the FSM returns to IDLE.
- `sram_dout` is sampled only in WRITE, for non-first elements.

## Test plan
- Reset: hold `rst` 3 cycles with `in_valid`=1 -> `in_ready`=0, `sram_we`=0, all flags 0. After release, `in_ready`=1.
- First pass: stream addr 0..3 with psum 10,20,-5,7 and `in_first`=1, back-to-back -> 4 consecutive `sram_we` pulses, one cycle after each transfer, with `sram_din`=10,20,-5,7.
- Accumulate: SRAM[5]=100, send addr 5, psum -30, non-first -> READ of addr 5 with we=0, then write 70 the next cycle; `in_ready` low during READ.
- Saturation + ReLU: SRAM[9]=2^25-10, psum 50 -> write 2^25-1, `sat_flag`=1. SRAM[9]=-40, psum 15, `in_final` -> write 0, `sram_final_flag`=1.
- Done: 3136 final writes to addresses 0..3135 -> `done` pulses once, 1 cycle after the last write. One extra final write does not pulse `done`. Addr 3200 -> no `sram_we`, `addr_err`=1, counter unchanged.
- Reset in READ: assert `rst` during the READ of an accumulate -> no write occurs, state IDLE, final counter 0.
